// File: rtl/calc_arbiter_if.sv
// Bundles the two requester ports, the shared add/sub unit port and the status outputs of calc_arbiter.
// The ovf signal exists only when CALC_ARBITER_OVF_EN is defined.
interface calc_arbiter_if #(parameter int W = 6);
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         sub0, sub1;
  logic         gnt0, gnt1;
  logic         done0, done1;
  logic [W-1:0] result;
  logic         busy;
  logic [W-1:0] au_a, au_b;
  logic         au_sub;
  logic [W-1:0] au_result;
`ifdef CALC_ARBITER_OVF_EN
  logic         ovf;
`endif

  // The master side holds the requesters and the external add/sub unit.
  modport master (
    output req0, req1, a0, b0, a1, b1, sub0, sub1, au_result,
    input  gnt0, gnt1, done0, done1, result, busy, au_a, au_b, au_sub
`ifdef CALC_ARBITER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, sub0, sub1, au_result,
    output gnt0, gnt1, done0, done1, result, busy, au_a, au_b, au_sub
`ifdef CALC_ARBITER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter that lends one external W-bit add/sub unit to two requesters (IDLE -> EXEC -> DONE).
// Optional feature macro CALC_ARBITER_OVF_EN adds a registered carry/borrow flag, ovf.
module calc_arbiter #(
  parameter int W = 6
) (
  input logic         clk,
  input logic         rst,
  calc_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state, state_next;
  logic         last;      // requester granted most recently
  logic         winner;    // requester that owns the current operation
  logic         win_sel;
  logic         load;
  logic [W-1:0] op_a, op_b, res_q;
  logic         op_sub;
`ifdef CALC_ARBITER_OVF_EN
  logic         ovf_q;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    win_sel    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          load       = 1'b1;
          state_next = EXEC;
          // When both requesters contend, the one not granted last wins.
          win_sel    = (bus.req0 && bus.req1) ? ~last : bus.req1;
        end
      end
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= 1'b1;
      winner <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
      res_q  <= '0;
`ifdef CALC_ARBITER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      if (load) begin
        winner <= win_sel;
        op_a   <= win_sel ? bus.a1   : bus.a0;
        op_b   <= win_sel ? bus.b1   : bus.b0;
        op_sub <= win_sel ? bus.sub1 : bus.sub0;
      end
      if (state == EXEC) begin
        res_q <= bus.au_result;
`ifdef CALC_ARBITER_OVF_EN
        // Carry out of an add shows up as a wrapped sum smaller than a; a borrow is a < b.
        ovf_q <= op_sub ? (op_a < op_b) : (bus.au_result < op_a);
`endif
      end
      if (state == DONE) last <= winner;
    end
  end

  // The operand registers always drive the unit; they only change while loading out of IDLE.
  assign bus.au_a   = op_a;
  assign bus.au_b   = op_b;
  assign bus.au_sub = op_sub;
  assign bus.result = res_q;
  assign bus.busy   = (state != IDLE);
  assign bus.gnt0   = (state != IDLE) && !winner;
  assign bus.gnt1   = (state != IDLE) &&  winner;
  assign bus.done0  = (state == DONE) && !winner;
  assign bus.done1  = (state == DONE) &&  winner;
`ifdef CALC_ARBITER_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed self-checking bench for calc_arbiter; it also stands in for the external add/sub unit.
// Build with CALC_ARBITER_OVF_EN defined to check the ovf flag as well.
module tb_calc_arbiter;
  localparam int W = 6;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  calc_arbiter_if #(.W(W)) bus ();

  calc_arbiter #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.au_result = bus.au_sub ? (bus.au_a - bus.au_b) : (bus.au_a + bus.au_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.sub0 = 1'b0;
    bus.a1 = '0; bus.b1 = '0; bus.sub1 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Presents one request, drops it once latched and leaves the DUT in its DONE cycle.
  task automatic run_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
    if (who) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sub1 = sub; end
    else     begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sub0 = sub; end
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.au_sub} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.au_sub}); else passed++;
    checks++; if ({bus.result, bus.au_a, bus.au_b} !== 18'h0) $display("FAIL reset_data: got %h want 00000", {bus.result, bus.au_a, bus.au_b}); else passed++;
`ifdef CALC_ARBITER_OVF_EN
    checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf); else passed++;
`endif
  endtask

  task automatic test_single();
    bus.req0 = 1'b1; bus.a0 = 6'h02; bus.b0 = 6'h03; bus.sub0 = 1'b0;
    tick();
    // Operand inputs must be ignored once latched.
    bus.a0 = 6'h3f; bus.b0 = 6'h3f; bus.sub0 = 1'b1; bus.req0 = 1'b0;
    checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b10001) $display("FAIL single_exec_ctrl: got %b want 10001", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}); else passed++;
    checks++; if ({bus.au_a, bus.au_b, bus.au_sub} !== {6'h02, 6'h03, 1'b0}) $display("FAIL single_au: got %h want %h", {bus.au_a, bus.au_b, bus.au_sub}, {6'h02, 6'h03, 1'b0}); else passed++;
    tick();
    checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b10101) $display("FAIL single_done_ctrl: got %b want 10101", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}); else passed++;
    checks++; if (bus.result !== 6'h05) $display("FAIL single_result: got %h want 05", bus.result); else passed++;
    tick();
    checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b00000) $display("FAIL single_idle_ctrl: got %b want 00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}); else passed++;
    checks++; if ({bus.result, bus.au_a, bus.au_b} !== {6'h05, 6'h02, 6'h03}) $display("FAIL single_hold: got %h want %h", {bus.result, bus.au_a, bus.au_b}, {6'h05, 6'h02, 6'h03}); else passed++;
  endtask

  task automatic test_contention();
    do_reset();
    bus.req0 = 1'b1; bus.a0 = 6'h06; bus.b0 = 6'h03; bus.sub0 = 1'b1;
    bus.req1 = 1'b1; bus.a1 = 6'h04; bus.b1 = 6'h07; bus.sub1 = 1'b0;
    tick();
    checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) $display("FAIL cont_first_gnt: got %b want 10", {bus.gnt0, bus.gnt1}); else passed++;
    tick();
    checks++; if ({bus.done0, bus.done1, bus.result} !== {2'b10, 6'h03}) $display("FAIL cont_done0: got %h want %h", {bus.done0, bus.done1, bus.result}, {2'b10, 6'h03}); else passed++;
    bus.req0 = 1'b0;
    tick();
    checks++; if ({bus.busy, bus.done0, bus.done1} !== 3'b000) $display("FAIL cont_gap: got %b want 000", {bus.busy, bus.done0, bus.done1}); else passed++;
    tick();
    checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) $display("FAIL cont_second_gnt: got %b want 01", {bus.gnt0, bus.gnt1}); else passed++;
    tick();
    checks++; if ({bus.done0, bus.done1, bus.result} !== {2'b01, 6'h0b}) $display("FAIL cont_done1: got %h want %h", {bus.done0, bus.done1, bus.result}, {2'b01, 6'h0b}); else passed++;
    bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] want;
    do_reset();
    bus.req0 = 1'b1; bus.a0 = 6'h01; bus.b0 = 6'h01; bus.sub0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 6'h05; bus.b1 = 6'h02; bus.sub1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 6'h02 : 6'h03;
      tick();
      checks++; if ({bus.gnt0, bus.gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL rr_gnt%0d: got %b want %b", i, {bus.gnt0, bus.gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01); else passed++;
      tick();
      checks++; if ({bus.gnt0, bus.gnt1, bus.result} !== {((i % 2 == 0) ? 2'b10 : 2'b01), want}) $display("FAIL rr_done%0d: got %h want %h", i, {bus.gnt0, bus.gnt1, bus.result}, {((i % 2 == 0) ? 2'b10 : 2'b01), want}); else passed++;
      if (i == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      tick();
      checks++; if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b000) $display("FAIL rr_idle%0d: got %b want 000", i, {bus.gnt0, bus.gnt1, bus.busy}); else passed++;
    end
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL rr_stop: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    run_op(1'b1, 6'h00, 6'h0e, 1'b1);
    checks++; if ({bus.done1, bus.result} !== {1'b1, 6'h32}) $display("FAIL wrap_result: got %h want %h", {bus.done1, bus.result}, {1'b1, 6'h32}); else passed++;
`ifdef CALC_ARBITER_OVF_EN
    checks++; if (bus.ovf !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", bus.ovf); else passed++;
`endif
    tick();
  endtask

  task automatic test_overflow();
    run_op(1'b0, 6'h3f, 6'h01, 1'b0);
    checks++; if ({bus.done0, bus.result} !== {1'b1, 6'h00}) $display("FAIL ovf_add_result: got %h want %h", {bus.done0, bus.result}, {1'b1, 6'h00}); else passed++;
`ifdef CALC_ARBITER_OVF_EN
    checks++; if (bus.ovf !== 1'b1) $display("FAIL ovf_add_flag: got %b want 1", bus.ovf); else passed++;
`endif
    tick();
    run_op(1'b0, 6'h0d, 6'h09, 1'b0);
    checks++; if ({bus.done0, bus.result} !== {1'b1, 6'h16}) $display("FAIL ovf_plain_result: got %h want %h", {bus.done0, bus.result}, {1'b1, 6'h16}); else passed++;
`ifdef CALC_ARBITER_OVF_EN
    checks++; if (bus.ovf !== 1'b0) $display("FAIL ovf_plain_flag: got %b want 0", bus.ovf); else passed++;
`endif
    tick();
  endtask

  task automatic test_reset_mid_op();
    bus.req0 = 1'b1; bus.a0 = 6'h05; bus.b0 = 6'h05; bus.sub0 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    checks++; if (bus.gnt0 !== 1'b1) $display("FAIL mid_exec: got %b want 1", bus.gnt0); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.au_sub} !== 6'b0) $display("FAIL mid_ctrl: got %b want 000000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.au_sub}); else passed++;
    checks++; if ({bus.result, bus.au_a, bus.au_b} !== 18'h0) $display("FAIL mid_data: got %h want 00000", {bus.result, bus.au_a, bus.au_b}); else passed++;
    tick();
    checks++; if ({bus.done0, bus.busy, bus.result} !== 8'h00) $display("FAIL mid_no_done: got %h want 00", {bus.done0, bus.busy, bus.result}); else passed++;
    run_op(1'b0, 6'h07, 6'h01, 1'b1);
    checks++; if ({bus.done0, bus.done1, bus.result} !== {2'b10, 6'h06}) $display("FAIL mid_fresh: got %h want %h", {bus.done0, bus.done1, bus.result}, {2'b10, 6'h06}); else passed++;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_wrap();
    test_overflow();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
